// File: rtl/paramest_nn_mac_pkg.sv
// -----------------------------------------------------------------------------
// paramest_nn_mac_pkg
// Shared types, legality constants and the saturating narrowing helper used by
// the ParamEst NN multiply / multiply-accumulate pipeline.
//   stage_t    : one pipeline slot (valid, full-precision product, acc, last)
//   sat_t      : result of sat_narrow (clamped value + clamp flag)
//   sat_narrow : clamp a signed value into a signed range of 'width' bits
// -----------------------------------------------------------------------------
package paramest_nn_mac_pkg;

  localparam int NUM_STAGE_MIN = 1;
  localparam int NUM_STAGE_MAX = 4;

  // Common carrier width for products and sums; every datapath value is
  // sign-extended into it so a single helper serves all widths.
  localparam int MAX_W = 64;

  typedef struct packed {
    logic                    valid;
    logic signed [MAX_W-1:0] product;
    logic                    acc;
    logic                    last;
  } stage_t;

  typedef struct packed {
    logic signed [MAX_W-1:0] value;
    logic                    clamp;
  } sat_t;

  // Clamp v into [-2^(width-1), 2^(width-1)-1]; width must be below MAX_W.
  function automatic sat_t sat_narrow(input logic signed [MAX_W-1:0] v,
                                      input int unsigned             width);
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    sat_t                    r;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r.value = v;
    r.clamp = 1'b0;
    if (v > hi) begin
      r.value = hi;
      r.clamp = 1'b1;
    end else if (v < lo) begin
      r.value = lo;
      r.clamp = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/paramest_nn_mac_mult.sv
// -----------------------------------------------------------------------------
// paramest_nn_mac_mult
// Signedness-aware full-precision multiplier followed by NUM_LEVELS register
// levels (0 = purely combinational). Control bits travel with the product.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en_i        : global advance; all levels shift together when high
//   valid_i     : beat present at the input (accepted when en_i is high)
//   a_i, b_i    : operands, extended per DIN0_SIGNED / DIN1_SIGNED
//   acc_i,last_i: beat kind, carried alongside the product
//   stage_o     : slot presented to the accumulate / output stage
// -----------------------------------------------------------------------------
module paramest_nn_mac_mult
  import paramest_nn_mac_pkg::*;
#(
  parameter int DIN0_WIDTH  = 16,
  parameter int DIN1_WIDTH  = 12,
  parameter bit DIN0_SIGNED = 1'b0,
  parameter bit DIN1_SIGNED = 1'b1,
  parameter int NUM_LEVELS  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  valid_i,
  input  logic [DIN0_WIDTH-1:0] a_i,
  input  logic [DIN1_WIDTH-1:0] b_i,
  input  logic                  acc_i,
  input  logic                  last_i,
  output stage_t                stage_o
);

  // One extra bit lets an unsigned operand live inside a signed multiply.
  localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH + 1;

  logic signed [PROD_WIDTH-1:0] a_ext;
  logic signed [PROD_WIDTH-1:0] b_ext;
  logic signed [PROD_WIDTH-1:0] prod;
  stage_t                       head;

  if (DIN0_SIGNED) begin : g_a_sext
    assign a_ext = {{(PROD_WIDTH-DIN0_WIDTH){a_i[DIN0_WIDTH-1]}}, a_i};
  end else begin : g_a_zext
    assign a_ext = {{(PROD_WIDTH-DIN0_WIDTH){1'b0}}, a_i};
  end

  if (DIN1_SIGNED) begin : g_b_sext
    assign b_ext = {{(PROD_WIDTH-DIN1_WIDTH){b_i[DIN1_WIDTH-1]}}, b_i};
  end else begin : g_b_zext
    assign b_ext = {{(PROD_WIDTH-DIN1_WIDTH){1'b0}}, b_i};
  end

  // The product of the extended operands always fits PROD_WIDTH; no wrap.
  assign prod = a_ext * b_ext;
  assign head = '{valid: valid_i, product: MAX_W'(prod), acc: acc_i, last: last_i};

  if (NUM_LEVELS == 0) begin : g_comb
    assign stage_o = head;
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst_n, en_i};
  end else begin : g_pipe
    stage_t pipe_q [NUM_LEVELS];

    // NOTE: the pipe is only a few slots deep, so every slot (payload too) is
    // reset; this keeps stall-hold behaviour free of X right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < NUM_LEVELS; i++) pipe_q[i] <= '0;
      end else if (en_i) begin
        // NOTE: non-blocking assignment makes every level sample the previous
        // level's old value, so the shift order inside the loop is irrelevant.
        pipe_q[0] <= head;
        for (int i = 1; i < NUM_LEVELS; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign stage_o = pipe_q[NUM_LEVELS-1];
  end

endmodule

// File: rtl/paramest_nn_mac_pipe.sv
// -----------------------------------------------------------------------------
// paramest_nn_mac_pipe
// Pipelined multiply / multiply-accumulate with valid/ready flow control and
// saturating output narrowing. The multiplier pipe feeds a final stage that
// owns the accumulator and the output register.
//   ap_clk, ap_rst_n     : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake (in_ready = global advance)
//   in_a, in_b           : operands
//   in_acc, in_last      : beat kind (mul, acc, acc-closing)
//   out_valid/out_ready  : output handshake
//   out_data, out_ovf    : saturated result and its clamp flag
//   acc_busy             : an accumulation is open in the final stage
// -----------------------------------------------------------------------------
module paramest_nn_mac_pipe
  import paramest_nn_mac_pkg::*;
#(
  parameter int DIN0_WIDTH  = 16,
  parameter int DIN1_WIDTH  = 12,
  parameter bit DIN0_SIGNED = 1'b0,
  parameter bit DIN1_SIGNED = 1'b1,
  parameter int DOUT_WIDTH  = 28,
  parameter int ACC_WIDTH   = 32,
  parameter int NUM_STAGE   = 2
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DIN0_WIDTH-1:0]        in_a,
  input  logic [DIN1_WIDTH-1:0]        in_b,
  input  logic                         in_acc,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DOUT_WIDTH-1:0] out_data,
  output logic                         out_ovf,
  output logic                         acc_busy
);

  if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_stage
    $error("paramest_nn_mac_pipe: NUM_STAGE must be within 1..4");
  end
  if (ACC_WIDTH < DIN0_WIDTH + DIN1_WIDTH + 1 || ACC_WIDTH >= MAX_W) begin : g_bad_acc
    $error("paramest_nn_mac_pipe: ACC_WIDTH too small or too large");
  end
  if (DOUT_WIDTH < 2 || DOUT_WIDTH >= MAX_W) begin : g_bad_dout
    $error("paramest_nn_mac_pipe: DOUT_WIDTH out of range");
  end

  logic                         advance;
  stage_t                       last_s;
  logic                         out_valid_q, out_valid_d;
  logic signed [DOUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                         out_ovf_q, out_ovf_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                         sticky_q, sticky_d;
  logic                         busy_q, busy_d;
  logic signed [MAX_W-1:0]      acc_sum;
  sat_t                         acc_sat;
  sat_t                         res_sat;

  // Whole pipe moves as one; a full output register blocks everything.
  assign advance  = out_ready || !out_valid_q;
  assign in_ready = advance;

  paramest_nn_mac_mult #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .DIN0_SIGNED(DIN0_SIGNED),
    .DIN1_SIGNED(DIN1_SIGNED),
    .NUM_LEVELS (NUM_STAGE - 1)
  ) u_mult (
    .clk    (ap_clk),
    .rst_n  (ap_rst_n),
    .en_i   (advance),
    .valid_i(in_valid),
    .a_i    (in_a),
    .b_i    (in_b),
    .acc_i  (in_acc),
    .last_i (in_last),
    .stage_o(last_s)
  );

  always_comb begin
    // NOTE: every variable gets a hold/default value before any branch, so no
    // path leaves one unassigned and no latch can be inferred.
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    busy_d      = busy_q;
    acc_sum     = MAX_W'(acc_q) + last_s.product;
    acc_sat     = sat_narrow(acc_sum, ACC_WIDTH);
    res_sat     = sat_narrow(last_s.product, DOUT_WIDTH);

    if (advance) begin
      out_valid_d = 1'b0;
      if (last_s.valid) begin
        if (!last_s.acc) begin
          // Plain multiply: the accumulator is left alone even when open.
          out_valid_d = 1'b1;
          out_data_d  = res_sat.value[DOUT_WIDTH-1:0];
          out_ovf_d   = res_sat.clamp;
        end else if (!last_s.last) begin
          acc_d    = acc_sat.value[ACC_WIDTH-1:0];
          sticky_d = sticky_q | acc_sat.clamp;
          busy_d   = 1'b1;
        end else begin
          // Closing beat: report any clamp seen during the dot product.
          res_sat     = sat_narrow(acc_sat.value, DOUT_WIDTH);
          out_valid_d = 1'b1;
          out_data_d  = res_sat.value[DOUT_WIDTH-1:0];
          out_ovf_d   = sticky_q | acc_sat.clamp | res_sat.clamp;
          acc_d       = '0;
          sticky_d    = 1'b0;
          busy_d      = 1'b0;
        end
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{res_sat.value[MAX_W-1:DOUT_WIDTH]};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign acc_busy  = busy_q;

endmodule

// File: tb/tb_paramest_nn_mac_pipe.sv
// -----------------------------------------------------------------------------
// tb_paramest_nn_mac_pipe
// Scoreboard bench: drivers push hand-computed expected results when a beat is
// accepted, monitors pop and compare whenever a result is taken. dut2 uses the
// default configuration; dut3 (NUM_STAGE=3) is used for the backpressure run.
// -----------------------------------------------------------------------------
module tb_paramest_nn_mac_pipe;

  typedef struct {
    int data;
    bit ovf;
  } exp_t;

  logic clk;
  logic rst_n;

  logic               in_valid, in_ready, in_acc, in_last;
  logic [15:0]        in_a;
  logic [11:0]        in_b;
  logic               out_valid, out_ready, out_ovf, acc_busy;
  logic signed [27:0] out_data;

  logic               in_valid3, in_ready3, in_acc3, in_last3;
  logic [15:0]        in_a3;
  logic [11:0]        in_b3;
  logic               out_valid3, out_ready3, out_ovf3, acc_busy3;
  logic signed [27:0] out_data3;

  exp_t q2[$];
  exp_t q3[$];
  int   checks = 0;
  int   errors = 0;

  int a_tab   [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
  int b_tab   [8] = '{5, -3, 5, -3, 5, -3, 5, -3};
  int exp_tab [8] = '{5, -6, 15, -12, 25, -18, 35, -24};

  paramest_nn_mac_pipe dut2 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .acc_busy(acc_busy)
  );

  paramest_nn_mac_pipe #(.NUM_STAGE(3)) dut3 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_a(in_a3), .in_b(in_b3),
    .in_acc(in_acc3), .in_last(in_last3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_ovf(out_ovf3), .acc_busy(acc_busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; monitors sample on the
  // falling edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input int a, input int b, input bit acc, input bit last,
                      input bit push, input int exp_d, input bit exp_o);
    int   n;
    exp_t e;
    in_valid = 1'b1;
    in_a     = 16'(a);
    in_b     = 12'(b);
    in_acc   = acc;
    in_last  = last;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      #1;
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 0, 1);
    end else begin
      if (push) begin
        e.data = exp_d;
        e.ovf  = exp_o;
        q2.push_back(e);
      end
      step();
    end
    in_valid = 1'b0;
    in_acc   = 1'b0;
    in_last  = 1'b0;
  endtask

  // Monitor for dut2.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (q2.size() == 0) begin
          check("dut2_unexpected_result", 1, 0);
        end else begin
          e = q2.pop_front();
          check("dut2_data", out_data, e.data);
          check("dut2_ovf", out_ovf, e.ovf);
        end
      end
    end
  end

  // Monitor for dut3: a held result must match the scoreboard head while
  // stalled, and is consumed once out_ready is high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid3) begin
        if (q3.size() == 0) begin
          check("dut3_unexpected_result", 1, 0);
        end else if (out_ready3) begin
          e = q3.pop_front();
          check("dut3_data", out_data3, e.data);
        end else begin
          check("dut3_stall_hold", out_data3, q3[0].data);
        end
      end
    end
  end

  initial begin
    int   sent;
    int   n;
    exp_t e;
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_acc = 1'b0; in_last = 1'b0;
    in_valid3 = 1'b0; in_a3 = '0; in_b3 = '0; in_acc3 = 1'b0; in_last3 = 1'b0;
    out_ready = 1'b1;
    out_ready3 = 1'b1;

    idle(2);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_acc_busy", acc_busy, 0);
    rst_n = 1'b1;
    step();

    // Mixed-sign multiply and its latency (accept edge + one more edge).
    send(65535, -2048, 1'b0, 1'b0, 1'b1, -134215680, 1'b0);
    check("lat_not_yet", out_valid, 0);
    step();
    check("lat_valid", out_valid, 1);
    idle(3);

    // Dot product 300 - 800 + 1000.
    send(100, 3, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    step();
    check("mac_busy_1", acc_busy, 1);
    send(200, -4, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    step();
    check("mac_busy_2", acc_busy, 1);
    send(50, 20, 1'b1, 1'b1, 1'b1, 500, 1'b0);
    idle(2);
    check("mac_busy_done", acc_busy, 0);

    // Output narrowing clamps, both directions.
    send(65535, 2047, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    send(65535, 2047, 1'b1, 1'b1, 1'b1, 134217727, 1'b1);
    send(65535, -2048, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    send(65535, -2048, 1'b1, 1'b1, 1'b1, -134217728, 1'b1);
    idle(3);

    // Accumulator clamps at 2^31-1 on beat 17; 16 negative beats then bring
    // it to 32767, which narrows cleanly but must still flag the earlier clamp.
    for (int i = 0; i < 17; i++) send(65535, 2047, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 15; i++) send(65535, -2048, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    send(65535, -2048, 1'b1, 1'b1, 1'b1, 32767, 1'b1);
    send(2, 2, 1'b1, 1'b1, 1'b1, 4, 1'b0);
    idle(3);

    // Mul beat interleaved into an open accumulation.
    send(10, 10, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    send(2, 3, 1'b0, 1'b0, 1'b1, 6, 1'b0);
    send(1, 1, 1'b1, 1'b1, 1'b1, 101, 1'b0);
    idle(3);

    // Multiply edge operands.
    send(0, -2048, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    send(65535, 2047, 1'b0, 1'b1, 1'b1, 134150145, 1'b0);
    idle(3);

    // Reset with an open accumulation and a mul beat still in flight.
    send(5, 5, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    send(6, 6, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    send(3, 3, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    check("pre_reset_busy", acc_busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_ovf", out_ovf, 0);
    check("mid_rst_acc_busy", acc_busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    send(7, -7, 1'b0, 1'b0, 1'b1, -49, 1'b0);
    send(1, 1, 1'b1, 1'b1, 1'b1, 1, 1'b0);
    idle(4);

    // Backpressure on the 3-stage unit: 8 mul beats, out_ready low in
    // cycles 4..8 while the output register is already full.
    sent = 0;
    for (int cyc = 0; cyc < 60 && sent < 8; cyc++) begin
      out_ready3 = !(cyc >= 4 && cyc < 9);
      in_valid3  = 1'b1;
      in_a3      = 16'(a_tab[sent]);
      in_b3      = 12'(b_tab[sent]);
      #1;
      if (cyc >= 4 && cyc < 9) check("bp_in_ready_low", in_ready3, 0);
      if (in_ready3) begin
        e.data = exp_tab[sent];
        e.ovf  = 1'b0;
        q3.push_back(e);
        step();
        sent++;
      end else begin
        step();
      end
    end
    in_valid3  = 1'b0;
    out_ready3 = 1'b1;
    check("bp_all_sent", sent, 8);

    n = 0;
    while ((q2.size() != 0 || q3.size() != 0) && n < 100) begin
      step();
      n++;
    end
    check("drain_q2", q2.size(), 0);
    check("drain_q3", q3.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
